// File: rtl/lcd_nibble_driver.sv
// HD44780 4-bit-mode LCD pin driver: power-on init sequence, then one nibble per
// valid/ready handshake with setup, enable, hold and post-nibble wait timing.
module lcd_nibble_driver #(
    parameter int unsigned T_POWERUP  = 750000,
    parameter int unsigned T_INIT1    = 205000,
    parameter int unsigned T_INIT2    = 5000,
    parameter int unsigned T_INIT3    = 2000,
    parameter int unsigned T_SETUP    = 2,
    parameter int unsigned T_PULSE    = 12,
    parameter int unsigned T_HOLD     = 1,
    parameter int unsigned WAIT_NIB   = 50,
    parameter int unsigned WAIT_BYTE  = 2000,
    parameter int unsigned WAIT_CLEAR = 82000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] iLCD_data,
    input  logic       iLCD_rs,
    input  logic       iLCD_writeEN,
    input  logic       iLCD_reset,
    output logic       oLCD_response,
    output logic [3:0] oLCD_Data,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_ReadWrite,
    output logic       oLCD_StrataFlashControl
);

    localparam int unsigned CNT_W = 20;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t LD_POWERUP = CNT_W'(T_POWERUP - 1);
    localparam cnt_t LD_INIT1   = CNT_W'(T_INIT1 - 1);
    localparam cnt_t LD_INIT2   = CNT_W'(T_INIT2 - 1);
    localparam cnt_t LD_INIT3   = CNT_W'(T_INIT3 - 1);
    localparam cnt_t LD_SETUP   = CNT_W'(T_SETUP - 1);
    localparam cnt_t LD_PULSE   = CNT_W'(T_PULSE - 1);
    localparam cnt_t LD_HOLD    = CNT_W'(T_HOLD - 1);
    localparam cnt_t LD_NIB     = CNT_W'(WAIT_NIB - 1);
    localparam cnt_t LD_BYTE    = CNT_W'(WAIT_BYTE - 1);
    localparam cnt_t LD_CLEAR   = CNT_W'(WAIT_CLEAR - 1);

    typedef enum logic [3:0] {
        S_POWERUP,
        S_INIT_SETUP,
        S_INIT_PULSE,
        S_INIT_HOLD,
        S_INIT_WAIT,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [1:0] step_q, step_d;
    logic       flag_q, flag_d;
    logic [3:0] hi_q, hi_d;
    logic [3:0] data_q, data_d;
    logic       rs_q, rs_d;
    logic       e_q, e_d;
    logic       resp_q, resp_d;

    logic       cnt_zero;
    cnt_t       cnt_dec;
    logic [1:0] step_nxt;
    logic [7:0] byte_val;
    logic       is_clear;
    cnt_t       user_wait;

    // Wait loaded after each init nibble, indexed by init step.
    function automatic cnt_t init_wait(input logic [1:0] step);
        cnt_t w;
        case (step)
            2'd0:    w = LD_INIT1;
            2'd1:    w = LD_INIT2;
            default: w = LD_INIT3;
        endcase
        return w;
    endfunction

    // Init nibble sequence 3, 3, 3, 2 (last one switches the LCD to 4-bit mode).
    function automatic logic [3:0] init_nibble(input logic [1:0] step);
        return (step == 2'd3) ? 4'h2 : 4'h3;
    endfunction

    assign cnt_zero = (cnt_q == '0);
    assign cnt_dec  = cnt_q - CNT_W'(1);
    assign step_nxt = step_q + 2'd1;
    assign byte_val = {hi_q, data_q};
    assign is_clear = !rs_q && ((byte_val == 8'h01) || (byte_val == 8'h02) || (byte_val == 8'h03));

    // flag_q is already toggled here: 1 means the high nibble just went out.
    assign user_wait = flag_q ? LD_NIB : (is_clear ? LD_CLEAR : LD_BYTE);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= S_POWERUP;
            cnt_q   <= LD_POWERUP;
            step_q  <= 2'd0;
            flag_q  <= 1'b0;
            hi_q    <= 4'h0;
            data_q  <= 4'h0;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            flag_q  <= flag_d;
            hi_q    <= hi_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            e_q     <= e_d;
            resp_q  <= resp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_dec;
        step_d  = step_q;
        flag_d  = flag_q;
        hi_d    = hi_q;
        data_d  = data_q;
        rs_d    = rs_q;
        e_d     = e_q;

        if (iLCD_reset) begin
            state_d = S_POWERUP;
            cnt_d   = LD_POWERUP;
            step_d  = 2'd0;
            flag_d  = 1'b0;
            data_d  = 4'h0;
            rs_d    = 1'b0;
            e_d     = 1'b0;
        end else begin
            case (state_q)
                S_POWERUP: begin
                    if (cnt_zero) begin
                        state_d = S_INIT_SETUP;
                        cnt_d   = LD_SETUP;
                        step_d  = 2'd0;
                        data_d  = init_nibble(2'd0);
                        rs_d    = 1'b0;
                    end
                end
                S_INIT_SETUP: begin
                    if (cnt_zero) begin
                        state_d = S_INIT_PULSE;
                        cnt_d   = LD_PULSE;
                        e_d     = 1'b1;
                    end
                end
                S_INIT_PULSE: begin
                    if (cnt_zero) begin
                        state_d = S_INIT_HOLD;
                        cnt_d   = LD_HOLD;
                        e_d     = 1'b0;
                    end
                end
                S_INIT_HOLD: begin
                    if (cnt_zero) begin
                        state_d = S_INIT_WAIT;
                        cnt_d   = init_wait(step_q);
                    end
                end
                S_INIT_WAIT: begin
                    if (cnt_zero) begin
                        if (step_q == 2'd3) begin
                            state_d = S_IDLE;
                            flag_d  = 1'b0;
                        end else begin
                            state_d = S_INIT_SETUP;
                            cnt_d   = LD_SETUP;
                            step_d  = step_nxt;
                            data_d  = init_nibble(step_nxt);
                            rs_d    = 1'b0;
                        end
                    end
                end
                S_IDLE: begin
                    if (iLCD_writeEN) begin
                        state_d = S_SETUP;
                        cnt_d   = LD_SETUP;
                        data_d  = iLCD_data;
                        rs_d    = iLCD_rs;
                        flag_d  = !flag_q;
                        if (!flag_q) begin
                            hi_d = iLCD_data;
                        end
                    end
                end
                S_SETUP: begin
                    if (cnt_zero) begin
                        state_d = S_PULSE;
                        cnt_d   = LD_PULSE;
                        e_d     = 1'b1;
                    end
                end
                S_PULSE: begin
                    if (cnt_zero) begin
                        state_d = S_HOLD;
                        cnt_d   = LD_HOLD;
                        e_d     = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (cnt_zero) begin
                        state_d = S_WAIT;
                        cnt_d   = user_wait;
                    end
                end
                S_WAIT: begin
                    if (cnt_zero) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_POWERUP;
                    cnt_d   = LD_POWERUP;
                    e_d     = 1'b0;
                end
            endcase
        end

        resp_d = (state_d == S_IDLE);
    end

    assign oLCD_response           = resp_q;
    assign oLCD_Data               = data_q;
    assign oLCD_Enabled            = e_q;
    assign oLCD_RegisterSelect     = rs_q;
    assign oLCD_ReadWrite          = 1'b0;
    assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_nibble_driver.sv
// Bench for lcd_nibble_driver: schedule-based reference model checked every cycle,
// directed latency checks with literal expectations, then randomized traffic.
module tb_lcd_nibble_driver;

    localparam int TPW = 10;
    localparam int TI1 = 8;
    localparam int TI2 = 4;
    localparam int TI3 = 4;
    localparam int TS  = 2;
    localparam int TPU = 3;
    localparam int TH  = 1;
    localparam int WN  = 2;
    localparam int WB  = 5;
    localparam int WC  = 20;

    logic       clk;
    logic       rst_n;
    logic [3:0] din;
    logic       rs_in;
    logic       wen;
    logic       lcd_reset;
    logic       resp;
    logic [3:0] dout;
    logic       e_out;
    logic       rs_out;
    logic       rw_out;
    logic       sf_out;

    int total;
    int bad;

    lcd_nibble_driver #(
        .T_POWERUP (TPW),
        .T_INIT1   (TI1),
        .T_INIT2   (TI2),
        .T_INIT3   (TI3),
        .T_SETUP   (TS),
        .T_PULSE   (TPU),
        .T_HOLD    (TH),
        .WAIT_NIB  (WN),
        .WAIT_BYTE (WB),
        .WAIT_CLEAR(WC)
    ) dut (
        .Clock                  (clk),
        .Reset                  (rst_n),
        .iLCD_data              (din),
        .iLCD_rs                (rs_in),
        .iLCD_writeEN           (wen),
        .iLCD_reset             (lcd_reset),
        .oLCD_response          (resp),
        .oLCD_Data              (dout),
        .oLCD_Enabled           (e_out),
        .oLCD_RegisterSelect    (rs_out),
        .oLCD_ReadWrite         (rw_out),
        .oLCD_StrataFlashControl(sf_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a list of scheduled nibble loads plus the edge at which ready returns.
    int         t_edge = 0;
    int         ready_at = 0;
    int         ld_q[$];
    logic [3:0] nd_q[$];
    logic       nr_q[$];
    logic       m_valid = 1'b0;
    logic       m_flag = 1'b0;
    logic [3:0] m_hi = 4'h0;
    logic       exp_resp = 1'b0;
    logic [3:0] exp_data = 4'h0;
    logic       exp_rs = 1'b0;
    logic       exp_e = 1'b0;

    always @(posedge clk) begin : model
        int         l;
        int         w;
        logic [7:0] b;
        int         iw[4];
        logic [3:0] inib[4];
        iw = '{TI1, TI2, TI3, TI3};
        inib = '{4'h3, 4'h3, 4'h3, 4'h2};
        t_edge = t_edge + 1;
        if (!rst_n || lcd_reset) begin
            ld_q.delete();
            nd_q.delete();
            nr_q.delete();
            l = t_edge + TPW;
            for (int i = 0; i < 4; i++) begin
                ld_q.push_back(l);
                nd_q.push_back(inib[i]);
                nr_q.push_back(1'b0);
                l = l + TS + TPU + TH + iw[i];
            end
            ready_at = l;
            m_flag = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid && wen && (t_edge - 1 >= ready_at)) begin
            if (!m_flag) begin
                w = WN;
                m_hi = din;
            end else begin
                b = {m_hi, din};
                w = (!rs_in && b >= 8'h01 && b <= 8'h03) ? WC : WB;
            end
            m_flag = !m_flag;
            ld_q.delete();
            nd_q.delete();
            nr_q.delete();
            ld_q.push_back(t_edge);
            nd_q.push_back(din);
            nr_q.push_back(rs_in);
            ready_at = t_edge + TS + TPU + TH + w;
        end
        exp_data = 4'h0;
        exp_rs = 1'b0;
        exp_e = 1'b0;
        for (int i = 0; i < ld_q.size(); i++) begin
            if (ld_q[i] <= t_edge) begin
                exp_data = nd_q[i];
                exp_rs = nr_q[i];
            end
            if (ld_q[i] + TS <= t_edge && t_edge < ld_q[i] + TS + TPU) exp_e = 1'b1;
        end
        exp_resp = (t_edge >= ready_at);
    end

    task automatic chk(input string nm, input int got, input int expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, expv);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!resp && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Waits for ready, presents one nibble for exactly one edge; returns just after that edge.
    task automatic accept(input logic [3:0] d, input logic r);
        int n;
        wait_ready(n);
        chk("ready_before_accept", int'(resp), 1);
        din = d;
        rs_in = r;
        wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic send(input string nm, input logic [3:0] d, input logic r, input int lat);
        int n;
        accept(d, r);
        wait_ready(n);
        chk(nm, n, lat);
    endtask

    initial begin
        int   n;
        int   pulses;
        logic prev_e;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        din = 4'h0;
        rs_in = 1'b0;
        wen = 1'b0;
        lcd_reset = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (m_valid) begin
                    total++;
                    if ({resp, dout, rs_out, e_out, rw_out, sf_out} !==
                        {exp_resp, exp_data, exp_rs, exp_e, 1'b0, 1'b1}) begin
                        bad++;
                        $display("FAIL cycle %0d: resp/data/rs/e/rw/sf got %b/%h/%b/%b/%b/%b expected %b/%h/%b/%b/0/1",
                                 t_edge, resp, dout, rs_out, e_out, rw_out, sf_out,
                                 exp_resp, exp_data, exp_rs, exp_e);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({resp, dout, rs_out, e_out, rw_out, sf_out}), 9'b0_0000_0001);

        // Power-up: four init pulses, ready 54 cycles after the last reset edge.
        rst_n = 1'b1;
        n = 0;
        pulses = 0;
        prev_e = e_out;
        while (!resp && n < 400) begin
            @(negedge clk);
            n++;
            if (e_out && !prev_e) pulses++;
            prev_e = e_out;
        end
        chk("powerup_latency", n, 54);
        chk("powerup_pulses", pulses, 4);

        send("data41_hi", 4'h4, 1'b1, 8);
        send("data41_lo", 4'h1, 1'b1, 11);
        send("clear_hi", 4'h0, 1'b0, 8);
        send("clear_lo", 4'h1, 1'b0, 26);
        send("entry_hi", 4'h0, 1'b0, 8);
        send("entry_lo", 4'h6, 1'b0, 11);

        // writeEN held high: one nibble per ready window.
        wait_ready(n);
        din = 4'h5;
        rs_in = 1'b1;
        wen = 1'b1;
        pulses = 0;
        prev_e = e_out;
        repeat (60) begin
            @(negedge clk);
            if (e_out && !prev_e) pulses++;
            prev_e = e_out;
        end
        wen = 1'b0;
        chk("held_wen_pulses", pulses, 6);
        wait_ready(n);

        // Soft re-init mid-pulse.
        accept(4'h2, 1'b0);
        repeat (2) @(negedge clk);
        chk("pulse_e_high", int'(e_out), 1);
        lcd_reset = 1'b1;
        @(negedge clk);
        lcd_reset = 1'b0;
        chk("softrst_e_low", int'(e_out), 0);
        chk("softrst_resp_low", int'(resp), 0);
        chk("softrst_data_zero", int'(dout), 0);
        wait_ready(n);
        chk("softrst_latency", n, 54);
        send("after_softrst_hi", 4'h0, 1'b0, 8);
        send("after_softrst_lo", 4'h1, 1'b0, 26);

        // Hard reset during the wait after a first nibble.
        accept(4'h3, 1'b0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midwait_reset_outputs", int'({resp, dout, rs_out, e_out, rw_out, sf_out}), 9'b0_0000_0001);
        rst_n = 1'b1;
        wait_ready(n);
        chk("rerun_init_latency", n, 54);
        send("after_reset_hi", 4'h0, 1'b0, 8);
        send("after_reset_lo", 4'h2, 1'b0, 26);

        // Randomized traffic, biased toward command nibbles that can form clear/home codes.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            wen = ($urandom_range(0, 3) != 0);
            rs_in = ($urandom_range(0, 2) == 0);
            if (!rs_in && $urandom_range(0, 1) == 0) din = 4'($urandom_range(0, 3));
            else din = 4'($urandom_range(0, 15));
            lcd_reset = ($urandom_range(0, 499) == 0);
            rst_n = ($urandom_range(0, 699) != 0);
        end
        @(negedge clk);
        wen = 1'b0;
        lcd_reset = 1'b0;
        rst_n = 1'b1;
        repeat (80) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
